// File: rtl/if_stage_if.sv
// Fetch-stage bus: redirect input, instruction-memory read channel and decode packet channel.
// The master modport is the fetch stage itself; the slave modport is its environment.
interface if_stage_if;
   logic        i_if_redirect;
   logic [63:0] i_if_redirect_pc;
   logic        o_if_rd_req;
   logic [63:0] o_if_rd_addr;
   logic        i_if_rd_ack;
   logic [31:0] i_if_rd_data;
   logic        o_if_fetched_req;
   logic        i_if_fetched_ack;
   logic [63:0] o_if_pc;
   logic [31:0] o_if_inst;
   logic [63:0] o_if_pc_old;
   logic [63:0] o_if_pc_pred;

   modport master (
      input  i_if_redirect, i_if_redirect_pc, i_if_rd_ack, i_if_rd_data, i_if_fetched_ack,
      output o_if_rd_req, o_if_rd_addr, o_if_fetched_req, o_if_pc, o_if_inst,
      o_if_pc_old, o_if_pc_pred
   );

   modport slave (
      output i_if_redirect, i_if_redirect_pc, i_if_rd_ack, i_if_rd_data, i_if_fetched_ack,
      input  o_if_rd_req, o_if_rd_addr, o_if_fetched_req, o_if_pc, o_if_inst,
      o_if_pc_old, o_if_pc_pred
   );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: one read in flight, one packet offered to decode, redirect with
// deferred flush so an outstanding memory read is always allowed to complete.
module if_stage #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic       clk,
   input  logic       rst,
   if_stage_if.master bus
);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_HOLD = 2'd1,
      ST_NEXT = 2'd2
   } state_t;

   state_t      r_state;
   logic        r_rd_req;
   logic        r_fetched_req;
   logic [63:0] r_fetch_pc;
   logic        r_flush;
   logic [63:0] r_flush_pc;
   logic [63:0] r_pc;
   logic [31:0] r_inst;
   logic [63:0] r_pc_old;

   logic [63:0] w_redir_pc;
   logic [63:0] w_pc_inc;
   logic        w_handshake;

   assign w_redir_pc  = bus.i_if_redirect_pc & ~64'h3;
   assign w_pc_inc    = r_pc + 64'd4;
   assign w_handshake = r_fetched_req & bus.i_if_fetched_ack;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_NEXT;
         r_rd_req      <= 1'b0;
         r_fetched_req <= 1'b0;
         r_fetch_pc    <= RESET_PC;
         r_flush       <= 1'b0;
         r_flush_pc    <= '0;
         r_pc          <= '0;
         r_inst        <= '0;
         r_pc_old      <= '0;
      end else begin
         case (r_state)
            ST_REQ: begin
               // A read is never cancelled on the bus; stale data is dropped when it returns.
               if (bus.i_if_rd_ack) begin
                  if (bus.i_if_redirect) begin
                     r_fetch_pc <= w_redir_pc;
                     r_flush    <= 1'b0;
                  end else if (r_flush) begin
                     r_fetch_pc <= r_flush_pc;
                     r_flush    <= 1'b0;
                  end else begin
                     r_pc          <= r_fetch_pc;
                     r_inst        <= bus.i_if_rd_data;
                     r_state       <= ST_HOLD;
                     r_rd_req      <= 1'b0;
                     r_fetched_req <= 1'b1;
                  end
               end else if (bus.i_if_redirect) begin
                  r_flush    <= 1'b1;
                  r_flush_pc <= w_redir_pc;
               end
            end
            ST_HOLD: begin
               if (w_handshake) begin
                  r_pc_old      <= r_pc;
                  r_fetch_pc    <= bus.i_if_redirect ? w_redir_pc : w_pc_inc;
                  r_state       <= ST_NEXT;
                  r_fetched_req <= 1'b0;
               end else if (bus.i_if_redirect) begin
                  r_fetch_pc    <= w_redir_pc;
                  r_state       <= ST_REQ;
                  r_rd_req      <= 1'b1;
                  r_fetched_req <= 1'b0;
               end
            end
            ST_NEXT: begin
               if (bus.i_if_redirect) begin
                  r_fetch_pc <= w_redir_pc;
               end
               r_state  <= ST_REQ;
               r_rd_req <= 1'b1;
            end
            default: begin
               r_state       <= ST_NEXT;
               r_rd_req      <= 1'b0;
               r_fetched_req <= 1'b0;
            end
         endcase
      end
   end

   // Packet fields are forced to zero whenever no packet is offered.
   assign bus.o_if_rd_req      = r_rd_req;
   assign bus.o_if_rd_addr     = r_fetch_pc;
   assign bus.o_if_fetched_req = r_fetched_req;
   assign bus.o_if_pc          = r_fetched_req ? r_pc     : 64'd0;
   assign bus.o_if_inst        = r_fetched_req ? r_inst   : 32'd0;
   assign bus.o_if_pc_pred     = r_fetched_req ? w_pc_inc : 64'd0;
   assign bus.o_if_pc_old      = r_pc_old;

endmodule

// File: tb/tb_if_stage.sv
// Directed and randomized bench for if_stage against a transaction-level fetch model.
// Memory content is a fixed function of address, so every delivered packet is checkable on its own.
module tb_if_stage;
   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   if_stage_if bus ();

   if_stage #(.RESET_PC(RESET_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: is a read expected, is a packet expected, and what addresses/PCs they carry.
   bit          m_reading;
   bit          m_pkt;
   bit          m_pend;
   logic [63:0] m_addr;
   logic [63:0] m_tgt;
   logic [63:0] m_pkt_pc;
   logic [63:0] m_pc_old;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return {a[31:2], 2'b11} ^ 32'h8000_0010;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_reading = 1'b0;
      m_pkt     = 1'b0;
      m_pend    = 1'b0;
      m_addr    = RESET_PC;
      m_tgt     = '0;
      m_pkt_pc  = '0;
      m_pc_old  = '0;
   endtask

   task automatic model_step(input bit redir, input logic [63:0] tgt_raw, input bit rack,
                             input bit fack);
      logic [63:0] tgt;
      tgt = {tgt_raw[63:2], 2'b00};
      if (m_reading) begin
         if (rack && redir) begin
            m_addr = tgt;
            m_pend = 1'b0;
         end else if (rack && m_pend) begin
            m_addr = m_tgt;
            m_pend = 1'b0;
         end else if (rack) begin
            m_reading = 1'b0;
            m_pkt     = 1'b1;
            m_pkt_pc  = m_addr;
         end else if (redir) begin
            m_pend = 1'b1;
            m_tgt  = tgt;
         end
      end else if (m_pkt) begin
         if (fack) begin
            m_pc_old = m_pkt_pc;
            m_addr   = redir ? tgt : m_pkt_pc + 64'd4;
            m_pkt    = 1'b0;
         end else if (redir) begin
            m_addr    = tgt;
            m_pkt     = 1'b0;
            m_reading = 1'b1;
         end
      end else begin
         if (redir) m_addr = tgt;
         m_reading = 1'b1;
      end
   endtask

   task automatic check_outputs();
      check("rd_req", bus.o_if_rd_req, m_reading);
      if (m_reading) check("rd_addr", bus.o_if_rd_addr, m_addr);
      check("fetched_req", bus.o_if_fetched_req, m_pkt);
      check("pc", bus.o_if_pc, m_pkt ? m_pkt_pc : 64'd0);
      check("inst", bus.o_if_inst, m_pkt ? mem_word(m_pkt_pc) : 32'd0);
      check("pc_pred", bus.o_if_pc_pred, m_pkt ? m_pkt_pc + 64'd4 : 64'd0);
      check("pc_old", bus.o_if_pc_old, m_pc_old);
   endtask

   // Called at a falling edge: check, drive this cycle's inputs, advance the model.
   task automatic tick(input bit redir, input logic [63:0] tgt, input bit rack, input bit fack);
      check_outputs();
      bus.i_if_redirect    = redir;
      bus.i_if_redirect_pc = tgt;
      bus.i_if_rd_ack      = rack;
      bus.i_if_rd_data     = rack ? mem_word(bus.o_if_rd_addr) : 32'hDEAD_BEEF;
      bus.i_if_fetched_ack = fack;
      model_step(redir, tgt, rack, fack);
      @(negedge clk);
   endtask

   task automatic apply_reset(input int n);
      bus.i_if_redirect    = 1'b0;
      bus.i_if_redirect_pc = '0;
      bus.i_if_rd_ack      = 1'b0;
      bus.i_if_rd_data     = '0;
      bus.i_if_fetched_ack = 1'b0;
      rst = 1'b1;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check("rst_rd_req", bus.o_if_rd_req, 1'b0);
         check("rst_fetched_req", bus.o_if_fetched_req, 1'b0);
         check("rst_pc_old", bus.o_if_pc_old, 64'd0);
      end
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [63:0] exp_addr [3];
      logic [63:0] prev;
      logic [63:0] rtgt;
      bit          rack;
      bit          redir;
      int          lat;

      // Back-to-back stream, decode ack held high, memory acks one cycle after request.
      apply_reset(2);
      exp_addr[0] = 64'h0000_0000_8000_0000;
      exp_addr[1] = 64'h0000_0000_8000_0004;
      exp_addr[2] = 64'h0000_0000_8000_0008;
      prev = 64'd0;
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 64'd0, 1'b0, 1'b1);
         check("seq_rd_req", bus.o_if_rd_req, 1'b1);
         check("seq_addr", bus.o_if_rd_addr, exp_addr[i]);
         tick(1'b0, 64'd0, 1'b0, 1'b1);
         tick(1'b0, 64'd0, 1'b1, 1'b1);
         check("seq_pc", bus.o_if_pc, exp_addr[i]);
         check("seq_pc_old", bus.o_if_pc_old, prev);
         prev = exp_addr[i];
         tick(1'b0, 64'd0, 1'b0, 1'b1);
      end
      check("seq_last_pc_old", bus.o_if_pc_old, 64'h0000_0000_8000_0008);

      // Decode stalls for five cycles with the first packet held.
      apply_reset(1);
      tick(1'b0, 64'd0, 1'b0, 1'b0);
      tick(1'b0, 64'd0, 1'b0, 1'b0);
      tick(1'b0, 64'd0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check("stall_pc", bus.o_if_pc, 64'h0000_0000_8000_0000);
         check("stall_inst", bus.o_if_inst, 32'h0000_0013);
         check("stall_no_rd", bus.o_if_rd_req, 1'b0);
         tick(1'b0, 64'd0, 1'b0, 1'b0);
      end
      tick(1'b0, 64'd0, 1'b0, 1'b1);

      // Redirect while the read of 8000_0004 is outstanding; ack three cycles later.
      tick(1'b0, 64'd0, 1'b0, 1'b0);
      check("flush_addr0", bus.o_if_rd_addr, 64'h0000_0000_8000_0004);
      tick(1'b1, 64'h0000_0000_8000_0100, 1'b0, 1'b0);
      tick(1'b0, 64'd0, 1'b0, 1'b0);
      tick(1'b0, 64'd0, 1'b0, 1'b0);
      check("flush_addr_held", bus.o_if_rd_addr, 64'h0000_0000_8000_0004);
      tick(1'b0, 64'd0, 1'b1, 1'b0);
      check("flush_no_pkt", bus.o_if_fetched_req, 1'b0);
      check("flush_new_addr", bus.o_if_rd_addr, 64'h0000_0000_8000_0100);
      tick(1'b0, 64'd0, 1'b1, 1'b0);
      check("flush_pkt_pc", bus.o_if_pc, 64'h0000_0000_8000_0100);

      // Redirect in HOLD together with decode ack: packet delivered, target aligned.
      tick(1'b1, 64'h0000_0000_8000_0203, 1'b0, 1'b1);
      check("hold_ack_pc_old", bus.o_if_pc_old, 64'h0000_0000_8000_0100);
      tick(1'b0, 64'd0, 1'b0, 1'b0);
      check("hold_ack_addr", bus.o_if_rd_addr, 64'h0000_0000_8000_0200);

      // Redirect with same-cycle ack to the top of the address space, then wrap.
      tick(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0);
      check("top_addr", bus.o_if_rd_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      tick(1'b0, 64'd0, 1'b1, 1'b0);
      check("wrap_pc_pred", bus.o_if_pc_pred, 64'd0);
      tick(1'b0, 64'd0, 1'b0, 1'b1);
      tick(1'b0, 64'd0, 1'b0, 1'b0);
      check("wrap_addr", bus.o_if_rd_addr, 64'd0);

      // Two redirects during one outstanding read: only the last target is fetched.
      tick(1'b1, 64'h0000_0000_0000_1000, 1'b0, 1'b0);
      tick(1'b1, 64'h0000_0000_0000_2002, 1'b0, 1'b0);
      tick(1'b0, 64'd0, 1'b1, 1'b0);
      check("last_tgt_addr", bus.o_if_rd_addr, 64'h0000_0000_0000_2000);
      tick(1'b0, 64'd0, 1'b1, 1'b0);
      tick(1'b1, 64'h0000_0000_0000_3000, 1'b0, 1'b0);
      check("hold_redir_drop", bus.o_if_fetched_req, 1'b0);
      check("hold_redir_addr", bus.o_if_rd_addr, 64'h0000_0000_0000_3000);
      tick(1'b0, 64'd0, 1'b1, 1'b0);
      tick(1'b0, 64'd0, 1'b0, 1'b1);
      tick(1'b1, 64'h0000_0000_0000_4000, 1'b0, 1'b0);
      check("next_redir_addr", bus.o_if_rd_addr, 64'h0000_0000_0000_4000);

      // Reset during an outstanding read, then a stray memory ack before the first request.
      apply_reset(1);
      tick(1'b0, 64'd0, 1'b1, 1'b0);
      check("stray_no_pkt", bus.o_if_fetched_req, 1'b0);
      check("stray_rd_req", bus.o_if_rd_req, 1'b1);
      check("stray_addr", bus.o_if_rd_addr, RESET_PC);
      tick(1'b0, 64'd0, 1'b1, 1'b0);
      check("stray_pc", bus.o_if_pc, RESET_PC);
      tick(1'b0, 64'd0, 1'b0, 1'b1);

      // Randomized traffic: variable memory latency, random decode stalls and redirects.
      apply_reset(1);
      lat = 0;
      for (int c = 0; c < 1200; c++) begin
         if (c == 600) begin
            apply_reset(1 + $urandom_range(0, 2));
            lat = 0;
         end
         rack = 1'b0;
         if (bus.o_if_rd_req === 1'b1) begin
            if (lat == 0) begin
               rack = 1'b1;
               lat  = $urandom_range(0, 3);
            end else begin
               lat--;
            end
         end
         redir = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 2))
            0:       rtgt = {$urandom, $urandom};
            1:       rtgt = 64'h0000_0000_8000_0000 + 64'($urandom_range(0, 255));
            default: rtgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
         endcase
         tick(redir, rtgt, rack, 1'($urandom_range(0, 1)));
      end
      check_outputs();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
